pci_cfg_target: RTL and testbench
=================================

// Module: pci_cfg_target
// PURPOSE
//  PCI target front end for Type 0 configuration transactions. Decodes the address phase
//  (IDSEL, C/BE#, AD), runs the FRAME#/IRDY#/TRDY#/DEVSEL#/STOP# handshake and AD/PAR
//  turnaround. Drives the register port of pci_cfg (cfg_enable/iswrite/offset/write_val)
//  and returns cfg_read_val onto AD. Memory cycles to BAR0 are handled by a separate block.
// PARAMETERS
//  FUNC_NUM   3'd0  function number claimed; other AD[10:8] values are ignored (no DEVSEL#)
// PORTS
//  clk            in   1   PCI clock
//  rst            in   1   asynchronous reset, active low
//  frame_n        in   1   PCI FRAME#
//  irdy_n         in   1   PCI IRDY#
//  idsel          in   1   PCI IDSEL
//  cbe_n          in   4   PCI C/BE#
//  ad_in          in   32  PCI AD, sampled
//  par_in         in   1   PCI PAR, sampled
//  ad_out         out  32  AD drive value
//  ad_oe          out  1   AD output enable
//  par_out        out  1   PAR drive value
//  par_oe         out  1   PAR output enable
//  trdy_n         out  1   TRDY# drive value
//  devsel_n       out  1   DEVSEL# drive value
//  stop_n         out  1   STOP# drive value
//  ctl_oe         out  1   enable for TRDY#/DEVSEL#/STOP#
//  cfg_enable     out  1   one-cycle register access strobe to pci_cfg
//  cfg_iswrite    out  1   1 = write access
//  cfg_offset     out  6   DWORD register index (AD[7:2] of address phase)
//  cfg_write_val  out  32  write data
//  cfg_byte_en    out  4   active-high byte enables (~C/BE#); pci_cfg currently ignores this port
//  cfg_read_val   in   32  read data, valid one clock after a read strobe
//  data_parity_error out 1 one-cycle pulse on write data parity mismatch
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE.
//    - Low: all *_oe, cfg_enable, cfg_iswrite, data_parity_error.
//    - High: trdy_n, devsel_n, stop_n.
//    - Zero: ad_out, par_out, cfg_offset, cfg_write_val, cfg_byte_en.
//    - Asserting reset mid-transaction floats the bus immediately.
//  - Address phase: first edge with frame_n=0 while the previous sample was frame_n=1, irdy_n=1.
//    Claim requires all of:
//    - idsel=1;
//    - AD[1:0]=00;
//    - AD[10:8]=FUNC_NUM;
//    - cbe_n=CMD_CFG_READ (4'b1010) or CMD_CFG_WRITE (4'b1011).
//    If not claimed -> BUSY until frame_n=1 and irdy_n=1, then IDLE. No outputs change.
//  - Fast DEVSEL#: ctl_oe=1 and devsel_n=0 on the clock after the address phase (N+1).
//  - Read, N+1 (RD_WAIT): cfg_enable=1, cfg_iswrite=0, cfg_offset latched.
//    AD is in turnaround, ad_oe=0.
//  - Read, N+2 onward (RD_DATA): ad_oe=1, ad_out=cfg_read_val (captured at N+2), trdy_n=0.
//    - Hold until irdy_n=0 is sampled with trdy_n=0.
//    - Next cycle: par_oe=1, par_out = ^{ad_out, cbe_n sampled at the transfer}.
//  - Write (WR_DATA), from N+1: trdy_n=0.
//    - On the edge with irdy_n=0: capture ad_in and ~cbe_n.
//    - Next cycle: cfg_enable=1, cfg_iswrite=1 for exactly one clock.
//    - Same next cycle: if par_in != ^{captured AD, captured C/BE#}, pulse data_parity_error.
//  - Burst: if frame_n=0 at the transfer edge, stop_n=0 with trdy_n=0 (disconnect with data).
//    stop_n stays 0 until frame_n=1 is sampled. Exactly one DWORD per transaction.
//  - Completion -> TURNAROUND for 1 cycle:
//    - trdy_n/devsel_n/stop_n driven high with ctl_oe=1;
//    - ad_oe=0; par_oe still 1 for a read.
//    Then IDLE with all oe=0.
//  - IDLE after TURNAROUND requires frame_n=1. Otherwise wait in BUSY (no re-claim mid-transaction).
//  - cfg_enable is never asserted for unclaimed cycles. cfg_offset/cfg_write_val hold between accesses.
//  - States: IDLE, BUSY, RD_WAIT, RD_DATA, WR_DATA, TURNAROUND (enum, one-hot not required).
// STRUCTURE
//  - pci_pkg: CMD_CFG_READ/CMD_CFG_WRITE, the other C/BE# command codes, and the state enum typedef.
//  - One sub-module, pci_par_gen: combinational 36-bit XOR (32 AD + 4 C/BE#).
//    Shared by the read PAR path and the write check.
// TESTING
//  1. Cfg read, idsel=1, AD=32'h0000_0000, cbe_n=1010, irdy_n=0 at N+1:
//     devsel_n=0 @N+1, cfg_enable @N+1 offset 0, ad_out=32'h11E8_1234 with trdy_n=0 @N+2,
//     par_out valid @N+3.
//  2. Cfg write, AD=32'h0000_0004, data 32'h0000_0006, cbe_n=0000, irdy_n=0 @N+1:
//     cfg_enable+iswrite @N+2, offset 1, write_val 6, byte_en F. Host delays irdy 3 clocks
//     -> trdy held, single strobe.
//  3. Write with wrong par_in -> data_parity_error pulses exactly 1 clock; access still issued.
//  4. Unclaimed: idsel=0, or cbe_n=0110, or AD[10:8]=3'd1 -> devsel_n/ctl_oe never asserted,
//     cfg_enable never 1.
//  5. Burst read (frame_n held low) -> stop_n=0 with first trdy_n=0, one DWORD transferred,
//     turnaround, IDLE.
//  6. rst=0 asserted in RD_DATA -> ad_oe/ctl_oe/par_oe drop immediately; next config read
//     completes normally.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared PCI definitions: C/BE# command codes, target state encoding and the
// 36-bit parity helper used for the PAR path and the write-data check.
package pci_pkg;

    typedef enum logic [3:0] {
        CMD_INT_ACK       = 4'b0000,
        CMD_SPECIAL       = 4'b0001,
        CMD_IO_READ       = 4'b0010,
        CMD_IO_WRITE      = 4'b0011,
        CMD_MEM_READ      = 4'b0110,
        CMD_MEM_WRITE     = 4'b0111,
        CMD_CFG_READ      = 4'b1010,
        CMD_CFG_WRITE     = 4'b1011,
        CMD_MEM_READ_MULT = 4'b1100,
        CMD_DUAL_ADDR     = 4'b1101,
        CMD_MEM_READ_LINE = 4'b1110,
        CMD_MEM_WRITE_INV = 4'b1111
    } pci_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BUSY       = 3'd1,
        ST_RD_WAIT    = 3'd2,
        ST_RD_DATA    = 3'd3,
        ST_WR_DATA    = 3'd4,
        ST_TURNAROUND = 3'd5
    } pci_state_e;

    function automatic logic calc_par(input logic [31:0] ad, input logic [3:0] cbe);
        return ^{ad, cbe};
    endfunction

endpackage

// File: rtl/pci_par_gen.sv
// Even parity over AD and C/BE#, shared by the read PAR drive and the
// write-data parity check.
module pci_par_gen
    import pci_pkg::*;
(
    input  logic [31:0] ad,
    input  logic [3:0]  cbe,
    output logic        par
);

    assign par = calc_par(ad, cbe);

endmodule

// File: rtl/pci_cfg_target.sv
// Type 0 configuration target: address decode, fast-DEVSEL# handshake,
// single-DWORD transfers with disconnect on bursts, and the pci_cfg register port.
module pci_cfg_target
    import pci_pkg::*;
#(
    parameter logic [2:0] FUNC_NUM = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_n,
    input  logic        irdy_n,
    input  logic        idsel,
    input  logic [3:0]  cbe_n,
    input  logic [31:0] ad_in,
    input  logic        par_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        par_out,
    output logic        par_oe,
    output logic        trdy_n,
    output logic        devsel_n,
    output logic        stop_n,
    output logic        ctl_oe,
    output logic        cfg_enable,
    output logic        cfg_iswrite,
    output logic [5:0]  cfg_offset,
    output logic [31:0] cfg_write_val,
    output logic [3:0]  cfg_byte_en,
    input  logic [31:0] cfg_read_val,
    output logic        data_parity_error
);

    pci_state_e  state_r, state_nx_s;
    logic        frame_q_r, irdy_q_r;
    logic        done_r, done_nx_s;
    logic [31:0] ad_out_r, ad_out_nx_s;
    logic        ad_oe_r, ad_oe_nx_s;
    logic        par_out_r, par_out_nx_s;
    logic        par_oe_r, par_oe_nx_s;
    logic        trdy_n_r, trdy_n_nx_s;
    logic        devsel_n_r, devsel_n_nx_s;
    logic        stop_n_r, stop_n_nx_s;
    logic        ctl_oe_r, ctl_oe_nx_s;
    logic        enable_r, enable_nx_s;
    logic        iswrite_r, iswrite_nx_s;
    logic [5:0]  offset_r, offset_nx_s;
    logic [31:0] write_val_r, write_val_nx_s;
    logic [3:0]  byte_en_r, byte_en_nx_s;
    logic        dpe_r, dpe_nx_s;

    logic        addr_phase_s;
    logic        claim_s;
    logic        xfer_s;
    logic [31:0] par_ad_s;
    logic        par_s;

    assign addr_phase_s = !frame_n && frame_q_r && irdy_q_r;
    assign claim_s      = idsel && (ad_in[1:0] == 2'b00) && (ad_in[10:8] == FUNC_NUM) &&
                          ((cbe_n == CMD_CFG_READ) || (cbe_n == CMD_CFG_WRITE));
    assign xfer_s       = !trdy_n_r && !irdy_n && !done_r;

    // Read parity covers the data we drove; write parity covers the data we sampled.
    assign par_ad_s = (state_r == ST_RD_DATA) ? ad_out_r : ad_in;

    pci_par_gen u_par_gen (
        .ad  (par_ad_s),
        .cbe (cbe_n),
        .par (par_s)
    );

    // Next-state and next-output decode for the target handshake.
    always_comb begin
        state_nx_s     = state_r;
        done_nx_s      = done_r;
        ad_out_nx_s    = ad_out_r;
        ad_oe_nx_s     = ad_oe_r;
        par_out_nx_s   = par_out_r;
        par_oe_nx_s    = par_oe_r;
        trdy_n_nx_s    = trdy_n_r;
        devsel_n_nx_s  = devsel_n_r;
        stop_n_nx_s    = stop_n_r;
        ctl_oe_nx_s    = ctl_oe_r;
        offset_nx_s    = offset_r;
        write_val_nx_s = write_val_r;
        byte_en_nx_s   = byte_en_r;
        enable_nx_s    = 1'b0;
        iswrite_nx_s   = 1'b0;
        dpe_nx_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (addr_phase_s && claim_s) begin
                    ctl_oe_nx_s   = 1'b1;
                    devsel_n_nx_s = 1'b0;
                    stop_n_nx_s   = 1'b1;
                    done_nx_s     = 1'b0;
                    offset_nx_s   = ad_in[7:2];
                    if (cbe_n == CMD_CFG_READ) begin
                        state_nx_s  = ST_RD_WAIT;
                        enable_nx_s = 1'b1;
                    end else begin
                        state_nx_s  = ST_WR_DATA;
                        trdy_n_nx_s = 1'b0;
                    end
                end else if (addr_phase_s) begin
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (frame_n && irdy_n) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_RD_WAIT: begin
                state_nx_s  = ST_RD_DATA;
                ad_oe_nx_s  = 1'b1;
                ad_out_nx_s = cfg_read_val;
                trdy_n_nx_s = 1'b0;
                stop_n_nx_s = frame_n | irdy_n;
            end
            ST_RD_DATA, ST_WR_DATA: begin
                if (xfer_s) begin
                    done_nx_s   = 1'b1;
                    trdy_n_nx_s = 1'b1;
                    if (state_r == ST_RD_DATA) begin
                        par_oe_nx_s  = 1'b1;
                        par_out_nx_s = par_s;
                    end else begin
                        write_val_nx_s = ad_in;
                        byte_en_nx_s   = ~cbe_n;
                        enable_nx_s    = 1'b1;
                        iswrite_nx_s   = 1'b1;
                        dpe_nx_s       = par_in ^ par_s;
                    end
                end else begin
                    done_nx_s = done_r;
                end
                // Only one DWORD per transaction: a still-asserted FRAME# gets STOP#.
                if (frame_n && (xfer_s || done_r)) begin
                    state_nx_s    = ST_TURNAROUND;
                    trdy_n_nx_s   = 1'b1;
                    devsel_n_nx_s = 1'b1;
                    stop_n_nx_s   = 1'b1;
                    ad_oe_nx_s    = 1'b0;
                end else if (xfer_s || done_r) begin
                    stop_n_nx_s = 1'b0;
                end else begin
                    stop_n_nx_s = frame_n | irdy_n;
                end
            end
            ST_TURNAROUND: begin
                ctl_oe_nx_s = 1'b0;
                par_oe_nx_s = 1'b0;
                if (frame_n) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                ad_oe_nx_s    = 1'b0;
                par_oe_nx_s   = 1'b0;
                ctl_oe_nx_s   = 1'b0;
                trdy_n_nx_s   = 1'b1;
                devsel_n_nx_s = 1'b1;
                stop_n_nx_s   = 1'b1;
            end
        endcase
    end

    // State, bus-history and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            frame_q_r   <= 1'b1;
            irdy_q_r    <= 1'b1;
            done_r      <= 1'b0;
            ad_out_r    <= 32'h0000_0000;
            ad_oe_r     <= 1'b0;
            par_out_r   <= 1'b0;
            par_oe_r    <= 1'b0;
            trdy_n_r    <= 1'b1;
            devsel_n_r  <= 1'b1;
            stop_n_r    <= 1'b1;
            ctl_oe_r    <= 1'b0;
            enable_r    <= 1'b0;
            iswrite_r   <= 1'b0;
            offset_r    <= 6'd0;
            write_val_r <= 32'h0000_0000;
            byte_en_r   <= 4'h0;
            dpe_r       <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            frame_q_r   <= frame_n;
            irdy_q_r    <= irdy_n;
            done_r      <= done_nx_s;
            ad_out_r    <= ad_out_nx_s;
            ad_oe_r     <= ad_oe_nx_s;
            par_out_r   <= par_out_nx_s;
            par_oe_r    <= par_oe_nx_s;
            trdy_n_r    <= trdy_n_nx_s;
            devsel_n_r  <= devsel_n_nx_s;
            stop_n_r    <= stop_n_nx_s;
            ctl_oe_r    <= ctl_oe_nx_s;
            enable_r    <= enable_nx_s;
            iswrite_r   <= iswrite_nx_s;
            offset_r    <= offset_nx_s;
            write_val_r <= write_val_nx_s;
            byte_en_r   <= byte_en_nx_s;
            dpe_r       <= dpe_nx_s;
        end
    end

    assign ad_out            = ad_out_r;
    assign ad_oe             = ad_oe_r;
    assign par_out           = par_out_r;
    assign par_oe            = par_oe_r;
    assign trdy_n            = trdy_n_r;
    assign devsel_n          = devsel_n_r;
    assign stop_n            = stop_n_r;
    assign ctl_oe            = ctl_oe_r;
    assign cfg_enable        = enable_r;
    assign cfg_iswrite       = iswrite_r;
    assign cfg_offset        = offset_r;
    assign cfg_write_val     = write_val_r;
    assign cfg_byte_en       = byte_en_r;
    assign data_parity_error = dpe_r;

endmodule

// File: tb/tb_pci_cfg_target.sv
// Directed bench for pci_cfg_target: a pci_cfg read model, monitors logging register
// strobes and read-data transfers, and scoreboards of expected accesses.
module tb_pci_cfg_target;

    logic        clk;
    logic        rst;
    logic        frame_n, irdy_n, idsel, par_in;
    logic [3:0]  cbe_n;
    logic [31:0] ad_in;
    logic [31:0] ad_out;
    logic        ad_oe, par_out, par_oe, trdy_n, devsel_n, stop_n, ctl_oe;
    logic        cfg_enable, cfg_iswrite, data_parity_error;
    logic [5:0]  cfg_offset;
    logic [31:0] cfg_write_val, cfg_read_val;
    logic [3:0]  cfg_byte_en;

    int vectors = 0;
    int miscompares = 0;

    logic [42:0] exp_q[$];
    logic [42:0] obs_log[$];
    logic [31:0] rd_exp_q[$];
    logic [31:0] rd_log[$];
    int          strobe_rd = 0;
    int          read_rd = 0;
    int          ctl_cnt = 0;
    int          dpe_cnt = 0;

    pci_cfg_target #(.FUNC_NUM(3'd0)) dut (
        .clk               (clk),
        .rst               (rst),
        .frame_n           (frame_n),
        .irdy_n            (irdy_n),
        .idsel             (idsel),
        .cbe_n             (cbe_n),
        .ad_in             (ad_in),
        .par_in            (par_in),
        .ad_out            (ad_out),
        .ad_oe             (ad_oe),
        .par_out           (par_out),
        .par_oe            (par_oe),
        .trdy_n            (trdy_n),
        .devsel_n          (devsel_n),
        .stop_n            (stop_n),
        .ctl_oe            (ctl_oe),
        .cfg_enable        (cfg_enable),
        .cfg_iswrite       (cfg_iswrite),
        .cfg_offset        (cfg_offset),
        .cfg_write_val     (cfg_write_val),
        .cfg_byte_en       (cfg_byte_en),
        .cfg_read_val      (cfg_read_val),
        .data_parity_error (data_parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cfg_model(input logic [5:0] off);
        return (off == 6'd0) ? 32'h11E8_1234 : {8'hC0, 18'h0, off};
    endfunction

    function automatic logic par36(input logic [31:0] a, input logic [3:0] c);
        return ^{a, c};
    endfunction

    function automatic logic [42:0] entry(input logic w, input logic [5:0] off,
                                          input logic [31:0] wv, input logic [3:0] be);
        return {w, off, wv, be};
    endfunction

    assign cfg_read_val = cfg_model(cfg_offset);

    always @(negedge clk) begin
        if (cfg_enable === 1'b1)
            obs_log.push_back({cfg_iswrite, cfg_offset, cfg_write_val, cfg_byte_en});
        if (trdy_n === 1'b0 && irdy_n === 1'b0 && ad_oe === 1'b1)
            rd_log.push_back(ad_out);
        if (ctl_oe === 1'b1 || devsel_n === 1'b0)
            ctl_cnt++;
        if (data_parity_error === 1'b1)
            dpe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_strobes(input string tag);
        logic [42:0] e;
        check({tag, "_count"}, 64'(obs_log.size()), 64'(strobe_rd + exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (strobe_rd < obs_log.size()) begin
                check(tag, 64'(obs_log[strobe_rd]), 64'(e));
                strobe_rd++;
            end
        end
        strobe_rd = obs_log.size();
    endtask

    task automatic check_reads(input string tag);
        logic [31:0] e;
        check({tag, "_count"}, 64'(rd_log.size()), 64'(read_rd + rd_exp_q.size()));
        while (rd_exp_q.size() > 0) begin
            e = rd_exp_q.pop_front();
            if (read_rd < rd_log.size()) begin
                check(tag, 64'(rd_log[read_rd]), 64'(e));
                read_rd++;
            end
        end
        read_rd = rd_log.size();
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd, input logic sel);
        frame_n = 1'b0;
        idsel   = sel;
        ad_in   = a;
        cbe_n   = cmd;
        tick();
        idsel   = 1'b0;
    endtask

    task automatic bus_idle();
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        cbe_n   = 4'hF;
        ad_in   = 32'h0;
        par_in  = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_wv;
        logic [3:0]  hold_be;
        logic [31:0] ua[3];
        logic [3:0]  uc[3];
        logic        us[3];
        int          c0, s0, d0;

        rst = 1'b0;
        idsel = 1'b0;
        bus_idle();
        hold_wv = 32'h0;
        hold_be = 4'h0;
        tick();
        tick();
        check("rst_oe", {61'd0, ad_oe, par_oe, ctl_oe}, 64'd0);
        check("rst_ctl", {61'd0, trdy_n, devsel_n, stop_n}, 64'd7);
        check("rst_strobe", {61'd0, cfg_enable, cfg_iswrite, data_parity_error}, 64'd0);
        check("rst_data", {21'd0, ad_out, par_out, cfg_offset, cfg_byte_en}, 64'd0);
        check("rst_wval", {32'd0, cfg_write_val}, 64'd0);
        rst = 1'b1;
        tick();
        tick();

        // Single config read of register 0
        exp_q.push_back(entry(1'b0, 6'd0, hold_wv, hold_be));
        rd_exp_q.push_back(32'h11E8_1234);
        addr_phase(32'h0000_0000, 4'b1010, 1'b1);
        check("t1_devsel", {62'd0, ctl_oe, devsel_n}, 64'h2);
        check("t1_strobe", {56'd0, cfg_enable, cfg_iswrite, cfg_offset}, 64'h80);
        check("t1_turn", {62'd0, ad_oe, trdy_n}, 64'h1);
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        cbe_n   = 4'b0000;
        tick();
        check("t1_data", {28'd0, ad_oe, trdy_n, stop_n, cfg_enable, ad_out},
              {28'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11E8_1234});
        tick();
        check("t1_par", {62'd0, par_oe, par_out}, {62'd0, 1'b1, par36(32'h11E8_1234, 4'h0)});
        check("t1_ta", {59'd0, ctl_oe, trdy_n, devsel_n, stop_n, ad_oe}, 64'h1E);
        bus_idle();
        tick();
        check("t1_idle", {61'd0, ctl_oe, ad_oe, par_oe}, 64'd0);
        check_strobes("t1_cfg");
        check_reads("t1_rd");

        // Config write to register 1 with the master holding IRDY# off for three clocks
        d0 = dpe_cnt;
        addr_phase(32'h0000_0004, 4'b1011, 1'b1);
        ad_in = 32'h0000_0006;
        check("t2_claim", {61'd0, ctl_oe, devsel_n, cfg_enable}, 64'h4);
        check("t2_wait0", {61'd0, trdy_n, stop_n, cfg_enable}, 64'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_wait", {61'd0, trdy_n, stop_n, cfg_enable}, 64'h2);
        end
        hold_wv = 32'h0000_0006;
        hold_be = 4'hF;
        exp_q.push_back(entry(1'b1, 6'd1, hold_wv, hold_be));
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        cbe_n   = 4'b0000;
        par_in  = par36(32'h0000_0006, 4'b0000);
        tick();
        check("t2_strobe", {56'd0, cfg_enable, cfg_iswrite, cfg_offset}, 64'hC1);
        check("t2_wval", {28'd0, cfg_byte_en, cfg_write_val}, {28'd0, 4'hF, 32'h0000_0006});
        check("t2_ta", {59'd0, ctl_oe, trdy_n, devsel_n, stop_n, data_parity_error}, 64'h1E);
        bus_idle();
        tick();
        check("t2_single", {62'd0, cfg_enable, ctl_oe}, 64'd0);
        check("t2_nodpe", 64'(dpe_cnt - d0), 64'd0);
        check_strobes("t2_cfg");

        // Write with bad parity: access still issued, error pulses once
        d0 = dpe_cnt;
        addr_phase(32'h0000_0008, 4'b1011, 1'b1);
        hold_wv = 32'hDEAD_BEEF;
        hold_be = 4'hC;
        exp_q.push_back(entry(1'b1, 6'd2, hold_wv, hold_be));
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        ad_in   = 32'hDEAD_BEEF;
        cbe_n   = 4'b0011;
        par_in  = ~par36(32'hDEAD_BEEF, 4'b0011);
        tick();
        check("t3_dpe", {62'd0, data_parity_error, cfg_enable}, 64'h3);
        bus_idle();
        tick();
        check("t3_dpe_end", {63'd0, data_parity_error}, 64'd0);
        check("t3_dpe_cnt", 64'(dpe_cnt - d0), 64'd1);
        check_strobes("t3_cfg");

        // Unclaimed cycles: no IDSEL, memory command, wrong function
        ua[0] = 32'h0000_0000; uc[0] = 4'b1010; us[0] = 1'b0;
        ua[1] = 32'h0000_0000; uc[1] = 4'b0110; us[1] = 1'b1;
        ua[2] = 32'h0000_0100; uc[2] = 4'b1010; us[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            c0 = ctl_cnt;
            s0 = obs_log.size();
            addr_phase(ua[k], uc[k], us[k]);
            frame_n = 1'b1;
            irdy_n  = 1'b0;
            cbe_n   = 4'b0000;
            tick();
            bus_idle();
            tick();
            tick();
            check("t4_ctl", 64'(ctl_cnt - c0), 64'd0);
            check("t4_cfg", 64'(obs_log.size() - s0), 64'd0);
        end

        // Burst read of register 3: disconnect with data after one DWORD
        exp_q.push_back(entry(1'b0, 6'd3, hold_wv, hold_be));
        rd_exp_q.push_back(cfg_model(6'd3));
        addr_phase(32'h0000_000C, 4'b1010, 1'b1);
        irdy_n = 1'b0;
        cbe_n  = 4'b0000;
        tick();
        check("t5_stop", {61'd0, trdy_n, stop_n, ad_oe}, 64'h1);
        check("t5_data", {32'd0, ad_out}, {32'd0, cfg_model(6'd3)});
        tick();
        check("t5_disc", {60'd0, trdy_n, stop_n, devsel_n, par_oe}, 64'h9);
        check("t5_par", {63'd0, par_out}, {63'd0, par36(cfg_model(6'd3), 4'h0)});
        frame_n = 1'b1;
        tick();
        check("t5_ta", {59'd0, ctl_oe, trdy_n, devsel_n, stop_n, ad_oe}, 64'h1E);
        bus_idle();
        tick();
        check("t5_idle", {61'd0, ctl_oe, ad_oe, par_oe}, 64'd0);
        check_strobes("t5_cfg");
        check_reads("t5_rd");

        // Reset during the read data phase
        exp_q.push_back(entry(1'b0, 6'd0, hold_wv, hold_be));
        addr_phase(32'h0000_0000, 4'b1010, 1'b1);
        frame_n = 1'b1;
        tick();
        check("t6_pre", {62'd0, ad_oe, trdy_n}, 64'h2);
        check_strobes("t6_cfg");
        #1;
        rst = 1'b0;
        #1;
        check("t6_float", {59'd0, ad_oe, ctl_oe, par_oe, trdy_n, devsel_n}, 64'h3);
        #1;
        rst = 1'b1;
        bus_idle();
        hold_wv = 32'h0;
        hold_be = 4'h0;
        tick();
        tick();
        exp_q.push_back(entry(1'b0, 6'd5, hold_wv, hold_be));
        rd_exp_q.push_back(cfg_model(6'd5));
        addr_phase(32'h0000_0014, 4'b1010, 1'b1);
        check("t6_devsel", {62'd0, ctl_oe, devsel_n}, 64'h2);
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        cbe_n   = 4'b0101;
        tick();
        check("t6_data", {31'd0, trdy_n, ad_out}, {32'd0, cfg_model(6'd5)});
        tick();
        check("t6_par", {62'd0, par_oe, par_out}, {62'd0, 1'b1, par36(cfg_model(6'd5), 4'b0101)});
        bus_idle();
        tick();
        check("t6_idle", {61'd0, ctl_oe, ad_oe, par_oe}, 64'd0);
        check_strobes("t6_cfg2");
        check_reads("t6_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
